// File: rtl/ashvin_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 (7,5) code, 4-state trellis,
// register-exchange survivors, in the Tiny Tapeout user-project pinout.
module ashvin_viterbi_decoder #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 6,
  parameter int PM_INIT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0]   PM_START = PM_W'(PM_INIT);

  logic r0, r1, in_valid, clear;
  assign r1       = ui_in[0];
  assign r0       = ui_in[1];
  assign in_valid = ui_in[2];
  assign clear    = ui_in[3];

  logic unused_inputs;
  assign unused_inputs = ^{uio_in, ui_in[7:4]};

  logic [PM_W-1:0]     pm_q   [4];
  logic [PM_W-1:0]     pm_d   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [TB_DEPTH-1:0] surv_d [4];
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                dec_valid_q, dec_valid_d;
  logic [7:0]          err_q, err_d;

  logic [PM_W-1:0]     acs_pm   [4];
  logic [TB_DEPTH-1:0] acs_surv [4];

  // New state gi is entered with input bit gi[1] from predecessors {gi[0],0} and {gi[0],1}.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_acs
    localparam int P0 = (gi % 2) * 2;
    localparam int P1 = P0 + 1;
    localparam bit B  = ((gi / 2) != 0);
    localparam bit S1 = ((gi % 2) != 0);

    logic [1:0]      bm0, bm1;
    logic [PM_W:0]   sum0, sum1;
    logic [PM_W-1:0] cand0, cand1;
    logic            take1;

    assign bm0   = {1'b0, r0 ^ (B ^ S1)} + {1'b0, r1 ^ B};
    assign bm1   = {1'b0, r0 ^ (B ^ S1 ^ 1'b1)} + {1'b0, r1 ^ ~B};
    assign sum0  = {1'b0, pm_q[P0]} + {{(PM_W-1){1'b0}}, bm0};
    assign sum1  = {1'b0, pm_q[P1]} + {{(PM_W-1){1'b0}}, bm1};
    assign cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
    assign cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
    // Strict compare so a tie keeps the s0=0 predecessor.
    assign take1 = (cand1 < cand0);

    assign acs_pm[gi]   = take1 ? cand1 : cand0;
    assign acs_surv[gi] = {take1 ? surv_q[P1][TB_DEPTH-2:0] : surv_q[P0][TB_DEPTH-2:0], B};
  end

  logic [PM_W-1:0] m;
  always_comb begin
    m = acs_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (acs_pm[i] < m) m = acs_pm[i];
    end
  end

  logic [8:0] err_sum;
  logic [7:0] err_sat;
  assign err_sum = {1'b0, err_q} + {{(9-PM_W){1'b0}}, m};
  assign err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_d[i]   = pm_q[i];
      surv_d[i] = surv_q[i];
    end
    fill_d      = fill_q;
    dec_valid_d = dec_valid_q;
    err_d       = err_q;
    if (ena) begin
      if (clear) begin
        for (int i = 0; i < 4; i++) begin
          pm_d[i]   = (i == 0) ? '0 : PM_START;
          surv_d[i] = '0;
        end
        fill_d      = '0;
        dec_valid_d = 1'b0;
        err_d       = '0;
      end else if (in_valid) begin
        for (int i = 0; i < 4; i++) begin
          pm_d[i]   = acs_pm[i] - m;
          surv_d[i] = acs_surv[i];
        end
        fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        dec_valid_d = (fill_q >= FILL_PRE);
        err_d       = err_sat;
      end else begin
        dec_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_START;
        surv_q[i] <= '0;
      end
      fill_q      <= '0;
      dec_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= pm_d[i];
        surv_q[i] <= surv_d[i];
      end
      fill_q      <= fill_d;
      dec_valid_q <= dec_valid_d;
      err_q       <= err_d;
    end
  end

  // Best state from the stored metrics; ties resolve to the lowest index.
  logic [1:0]      best;
  logic [PM_W-1:0] best_pm;
  always_comb begin
    best    = 2'd0;
    best_pm = pm_q[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_q[i] < best_pm) begin
        best    = 2'(i);
        best_pm = pm_q[i];
      end
    end
  end

  logic dec_bit, primed;
  assign dec_bit = surv_q[best][TB_DEPTH-1];
  assign primed  = (fill_q == FILL_MAX);

  assign uo_out  = {5'b0, primed, dec_valid_q, dec_bit};
  assign uio_out = err_q;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_ashvin_viterbi_decoder.sv
// Bench for ashvin_viterbi_decoder: encodes message tables with a reference encoder,
// queues the expected decisions and checks them as dec_valid pulses arrive.
module tb_ashvin_viterbi_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  ashvin_viterbi_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] head;       // message bits, first symbol in the MSB; zeros follow
    int          nsym;
    int          flip_a;     // symbol indices whose r0 is inverted (-1 = none)
    int          flip_b;
    bit          gapped;
    int          ena_gap_at; // symbol before which ena drops for 5 cycles (-1 = none)
    int          exp_err;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [5];

  int   n_cmp = 0;
  int   n_mis = 0;
  int   fill_m = 0;
  bit   dv_m = 1'b0;
  int   pulses = 0;
  bit   exp_q [$];
  logic [7:0] prev_uo, prev_uio;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit msg_bit(input logic [15:0] head, input int n);
    if (n >= 0 && n < 16) return head[15-n];
    return 1'b0;
  endfunction

  // One clock: drive inputs, advance the bench's own fill/valid model, check after the edge.
  task automatic cycle(input bit en, input bit vld, input bit clr, input bit r0, input bit r1);
    bit acc, clrd, exp_b;
    acc  = en && vld && !clr;
    clrd = en && clr;
    ena   = en;
    ui_in = {4'b0, clr, vld, r0, r1};
    if (clrd) begin
      fill_m = 0;
      dv_m   = 1'b0;
    end else if (acc) begin
      dv_m   = (fill_m >= 15);
      fill_m = (fill_m >= 16) ? 16 : fill_m + 1;
    end else if (en) begin
      dv_m = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("dec_valid", int'(uo_out[1]), int'(dv_m));
    chk("primed", int'(uo_out[2]), int'(fill_m == 16));
    chk("uo_hi_zero", int'(uo_out[7:3]), 0);
    if (!en) begin
      chk("hold_uo", int'(uo_out), int'(prev_uo));
      chk("hold_uio", int'(uio_out), int'(prev_uio));
    end
    if (acc && uo_out[1]) begin
      if (exp_q.size() == 0) begin
        chk("dec_unexpected", 1, 0);
      end else begin
        exp_b = exp_q.pop_front();
        chk("dec_bit", int'(uo_out[0]), int'(exp_b));
        pulses++;
      end
    end
    if (clrd) begin
      chk("clear_uo", int'(uo_out), 0);
      chk("clear_err", int'(uio_out), 0);
    end
    prev_uo  = uo_out;
    prev_uio = uio_out;
  endtask

  task automatic run_vec(input vec_t v);
    bit s1, s0, b, g0, g1, r0;
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);   // clear wins over in_valid
    pulses = 0;
    s1 = 1'b0;
    s0 = 1'b0;
    for (int n = 0; n < v.nsym; n++) begin
      if (n == v.ena_gap_at) begin
        for (int k = 0; k < 5; k++)
          cycle(1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
      end
      if (v.gapped && n > 0)
        cycle(1'b1, 1'b0, 1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
      b  = msg_bit(v.head, n);
      g0 = b ^ s1 ^ s0;
      g1 = b ^ s0;
      s0 = s1;
      s1 = b;
      r0 = g0 ^ ((n == v.flip_a) || (n == v.flip_b));
      if (fill_m >= 15) exp_q.push_back(msg_bit(v.head, n - 15));
      cycle(1'b1, 1'b1, 1'b0, r0, g1);
    end
    chk({v.name, "_err_count"}, int'(uio_out), v.exp_err);
    chk({v.name, "_pulses"}, pulses, v.exp_pulses);
    chk({v.name, "_queue_left"}, exp_q.size(), 0);
    $display("stream %s: %0d symbols, %0d pulses, err_count=%0d", v.name, v.nsym, pulses, uio_out);
  endtask

  initial begin
    vec_t pre;

    vecs[0] = '{"all_zero",   16'h0000, 32, -1, -1, 1'b0, -1, 0, 17};
    vecs[1] = '{"msg_clean",  16'hB38B, 33, -1, -1, 1'b0, -1, 0, 18};
    vecs[2] = '{"msg_2err",   16'hB38B, 33,  3, 20, 1'b0, -1, 2, 18};
    vecs[3] = '{"msg_gapped", 16'hB38B, 33, -1, -1, 1'b1, 20, 0, 18};
    vecs[4] = '{"msg2_1err",  16'hC3A5, 33, 10, -1, 1'b0, 25, 1, 18};

    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #2;
    chk("reset_uo_out", int'(uo_out), 0);
    chk("reset_uio_out", int'(uio_out), 0);
    chk("reset_uio_oe", int'(uio_oe), 8'hFF);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_uo  = uo_out;
    prev_uio = uio_out;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Clear after 20 symbols: one r0/r1 hit at symbol 5 makes err_count 2 beforehand.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (fill_m >= 15) exp_q.push_back(1'b0);
      cycle(1'b1, 1'b1, 1'b0, n == 5, n == 5);
    end
    chk("pre_clear_err", int'(uio_out), 2);
    chk("pre_clear_pulses", pulses, 5);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    for (int n = 0; n < 16; n++) begin
      if (fill_m >= 15) exp_q.push_back(1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("post_clear_pulses", pulses, 1);
    chk("post_clear_err", int'(uio_out), 0);
    $display("clear sequence: %0d pulse(s) after 16 symbols post-clear", pulses);

    // Asynchronous reset between edges while primed.
    pre = '{"pre_reset", 16'hB38B, 18, -1, -1, 1'b0, -1, 0, 3};
    run_vec(pre);
    chk("pre_reset_primed", int'(uo_out[2]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_uo", int'(uo_out), 0);
    chk("async_reset_uio", int'(uio_out), 0);
    chk("async_reset_oe", int'(uio_oe), 8'hFF);
    #2 rst_n = 1'b1;
    fill_m = 0;
    dv_m   = 1'b0;
    exp_q.delete();
    $display("async reset: uo_out=%0h uio_out=%0h uio_oe=%0h", uo_out, uio_out, uio_oe);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec(vecs[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
